// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: serial-in/parallel-out frame assembler.
// Shifts in d on each d_valid strobe and, after WIDTH accepted bits, presents
// the assembled word on d0 behind a word_valid/word_ready handshake. Bits that
// arrive while a finished word is still waiting are dropped and flagged by the
// sticky overrun flag.
module sipo_frame_ctrl #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MSB_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       d,
    input  logic                       d_valid,
    output logic [WIDTH-1:0]           d0,
    output logic                       word_valid,
    input  logic                       word_ready,
    output logic                       busy,
    output logic [$clog2(WIDTH)-1:0]   bit_cnt,
    output logic                       overrun
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_sr;
    logic [WIDTH-1:0]       r_d0;
    logic                   r_word_valid;
    logic                   r_busy;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic                   r_overrun;

    logic [WIDTH-1:0]       w_sr_next;
    logic                   w_last_bit;
    logic                   w_handshake;

    // Shift register contents after accepting the current d, in the configured bit order.
    always_comb begin
        w_sr_next = r_sr;
        if (MSB_FIRST != 0) begin
            w_sr_next = {r_sr[WIDTH-2:0], d};
        end else begin
            w_sr_next = {d, r_sr[WIDTH-1:1]};
        end
    end

    assign w_last_bit  = (r_bit_cnt == LAST_BIT);
    assign w_handshake = r_word_valid & word_ready;

    // Frame sequencer: state, shift register, counters and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sr         <= '0;
            r_d0         <= '0;
            r_word_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_bit_cnt    <= '0;
            r_overrun    <= 1'b0;
        end else begin
            case (r_state)
                // Serial input is ignored until a new frame is armed.
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_SHIFT;
                        r_busy    <= 1'b1;
                        r_bit_cnt <= '0;
                        r_overrun <= 1'b0;
                        r_sr      <= '0;
                    end
                end

                // Accept one bit per strobe; the last bit publishes the word.
                S_SHIFT: begin
                    if (d_valid) begin
                        r_sr <= w_sr_next;
                        if (w_last_bit) begin
                            r_d0         <= w_sr_next;
                            r_word_valid <= 1'b1;
                            r_bit_cnt    <= '0;
                            r_state      <= S_HOLD;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                        end
                    end
                end

                // Word waits for the consumer; incoming bits are dropped and flagged.
                S_HOLD: begin
                    if (d_valid) begin
                        r_overrun <= 1'b1;
                    end
                    if (w_handshake) begin
                        r_word_valid <= 1'b0;
                        if (start) begin
                            // Zero-bubble restart; a fresh start clears the overrun flag.
                            r_state   <= S_SHIFT;
                            r_busy    <= 1'b1;
                            r_bit_cnt <= '0;
                            r_overrun <= 1'b0;
                            r_sr      <= '0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_word_valid <= 1'b0;
                    r_bit_cnt    <= '0;
                end
            endcase
        end
    end

    assign d0         = r_d0;
    assign word_valid = r_word_valid;
    assign busy       = r_busy;
    assign bit_cnt    = r_bit_cnt;
    assign overrun    = r_overrun;

endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Frame-assembly controller for the serial-in/parallel-out path. It takes a single-bit serial stream qualified by a bit strobe and sequences an internal WIDTH-bit shift register. It counts accepted bits and, once a full frame is assembled, presents the word on a parallel output behind a valid/ready handshake. It sits between a serial source (bit-banged input, UART-style front end) and any parallel consumer, and adds framing, backpressure and overrun detection.

## Interface
Parameters:
- WIDTH, 4, frame length in bits and width of the parallel output; legal range 2..32.
- MSB_FIRST, 1, 1 = first accepted bit lands in d0[WIDTH-1]; 0 = first accepted bit lands in d0[0].

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  arm a new frame; sampled only in IDLE, or in HOLD during a handshake.
- d  input  1  serial data bit.
- d_valid  input  1  d is a valid bit this cycle.
- d0  output  WIDTH  assembled parallel word (registered).
- word_valid  output  1  d0 holds a complete, unconsumed frame.
- word_ready  input  1  consumer accepts d0 when word_valid=1.
- busy  output  1  high in SHIFT and HOLD.
- bit_cnt  output  $clog2(WIDTH)  bits accepted in the current frame, 0..WIDTH-1.
- overrun  output  1  sticky: a d_valid bit arrived while the controller was in HOLD.

## Operation
- States: IDLE, SHIFT, HOLD. Encoding is free.
- IDLE: ignore d/d_valid; no overrun in IDLE. start=1 -> SHIFT, bit_cnt<=0, overrun<=0, shift register<=0.
- SHIFT: each cycle with d_valid=1, shift d in.
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], d}.
  - MSB_FIRST=0: sr <= {d, sr[WIDTH-1:1]}.
  - Then bit_cnt<=bit_cnt+1.
  - d_valid=0: hold all state. Gaps of any length are legal.
  - start is ignored in SHIFT.
- Frame complete: on the edge that accepts a bit with bit_cnt==WIDTH-1:
  - d0 <= the shifted value, including that bit;
  - word_valid<=1, bit_cnt<=0, state -> HOLD.
- HOLD: d0 and word_valid are stable until handshake.
  - word_valid & word_ready: word_valid<=0 on that edge. start=1 in the same cycle -> SHIFT (same clearing as from IDLE); otherwise -> IDLE.
  - d_valid=1 in HOLD: the bit is discarded and overrun<=1, regardless of word_ready in that cycle.
- overrun stays set until the next accepted start or rst.
- d0 keeps its last value after the handshake. It changes only on frame completion or rst.

## Timing
- Reset values (asserted immediately, asynchronously): state=IDLE, d0=0, word_valid=0, busy=0, bit_cnt=0, overrun=0.
- rst mid-frame or in HOLD: partial frame and pending word are discarded. After release, start is required.
- start and d_valid in the same cycle from IDLE: the bit is not accepted. The first bit can be accepted on the edge after start is sampled.
- Latency: with back-to-back bits after start, word_valid rises on edge k+WIDTH (start sampled at edge k) and is visible the cycle after the last bit.
- busy = (state != IDLE), registered with state.
- Throughput: handshake+start in the same cycle gives zero-bubble restart. The next frame's first bit is accepted one edge later.
- word_ready while word_valid=0 has no effect.

## Test plan
All scenarios use WIDTH=4 unless stated.
- Basic, MSB_FIRST=1: start one cycle, then bits 1,0,1,1 on 4 consecutive cycles, word_ready=1 -> d0=4'b1011, word_valid high exactly one cycle, then IDLE, busy=0, overrun=0.
- Gapped input: bits 1,1,0,1 with d_valid low for 3 cycles between each -> bit_cnt steps 0,1,2,3, holds during gaps; d0=4'b1101.
- Backpressure/overrun: frame 0,1,1,0 with word_ready=0 for 5 cycles, d_valid=1 (d=1) in 2 of them -> d0=4'b0110 stable, word_valid held, overrun=1. Raise word_ready -> word_valid=0, overrun stays 1 until next start.
- Back-to-back: in HOLD, drive word_ready=1 and start=1 together, then bits 0,0,1,1 -> second d0=4'b0011, busy never drops, overrun=0.
- Reset mid-frame: after 2 bits assert rst -> all outputs 0 immediately. Release, start, bits 1,0,0,1 -> d0=4'b1001 (no stale bits).
- LSB-first: MSB_FIRST=0, bits 1,0,1,1 -> d0=4'b1101. Also WIDTH=8 MSB_FIRST=1 with bits 1,0,1,0,0,1,0,1 -> d0=8'hA5.
